hilo_muldiv_sequencer: RTL

- Multi-cycle sequencer that owns the HI/LO register pair.
- Executes mult, multu, madd, msub (iterative radix-2 shift-add, 32 iterations) and mthi/mtlo (single cycle).
- Sits beside the ALU in EX; the main decode supplies Op, and this block back-pressures the pipeline with Stall while a multiply is in flight.
- mfhi/mflo read Hi/Lo directly and are interlocked via ReadHiLo.

---
 rtl/hilo_muldiv_sequencer_pkg.sv | 24 ++
 rtl/hilo_muldiv_sequencer_core.sv | 62 ++++++
 rtl/hilo_muldiv_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: op encoding, FSM states, default width.
package hilo_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MADD  = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op >= OP_MULT) && (op <= OP_MSUB);
    endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_core.sv
// Radix-2 shift-add unsigned multiplier datapath; sequencing is owned by the parent FSM.
module shift_add_mul_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_last
);

    localparam int ITERS = WIDTH;
    localparam int CW    = $clog2(ITERS);

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;

    // Carry-extended add of the multiplicand into the upper accumulator half.
    always_comb begin
        w_addend = {(WIDTH+1){1'b0}};
        if (r_mplier[0]) begin
            w_addend = {1'b0, r_mcand};
        end else begin
            w_addend = {(WIDTH+1){1'b0}};
        end
        w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
    end

    // Operand capture on load, one shift-add iteration per step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_cnt    <= {CW{1'b0}};
        end else if (i_load) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_acc    <= {(2*WIDTH){1'b0}};
            r_cnt    <= {CW{1'b0}};
        end else if (i_step) begin
            r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + CW'(1);
        end else begin
            r_acc    <= r_acc;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == CW'(ITERS-1));

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO owner beside the EX ALU: multi-cycle mult/multu/madd/msub, single-cycle mthi/mtlo, pipeline stall.
module hilo_muldiv_sequencer
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    input  logic             ReadHiLo,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_t             r_state;
    logic [2:0]         r_op;
    logic               r_neg;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_mul;
    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic               w_neg;
    logic [WIDTH-1:0]   w_mcand;
    logic [WIDTH-1:0]   w_mplier;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_hilo;
    logic [2*WIDTH-1:0] w_result;

    assign w_is_mul = is_mul_op(Op);
    assign w_load   = (r_state == ST_IDLE) && Start && !Flush && w_is_mul;
    assign w_step   = (r_state == ST_MUL) && !Flush;

    // Signed ops multiply magnitudes; the most negative value's magnitude is read as unsigned.
    always_comb begin
        w_mcand  = A;
        w_mplier = B;
        w_neg    = 1'b0;
        if (Op != OP_MULTU) begin
            w_mcand  = A[WIDTH-1] ? (~A + {{(WIDTH-1){1'b0}}, 1'b1}) : A;
            w_mplier = B[WIDTH-1] ? (~B + {{(WIDTH-1){1'b0}}, 1'b1}) : B;
            w_neg    = A[WIDTH-1] ^ B[WIDTH-1];
        end else begin
            w_mcand  = A;
            w_mplier = B;
            w_neg    = 1'b0;
        end
    end

    shift_add_mul_core #(.WIDTH(WIDTH)) u_core (
        .i_clk    (Clk),
        .i_rst_n  (Reset_n),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_mcand  (w_mcand),
        .i_mplier (w_mplier),
        .o_acc    (w_acc),
        .o_last   (w_last)
    );

    // Sign fix-up of the magnitude product and optional accumulate into HI/LO.
    always_comb begin
        w_hilo = {r_hi, r_lo};
        w_prod = r_neg ? ({(2*WIDTH){1'b0}} - w_acc) : w_acc;
        case (r_op)
            OP_MADD: w_result = w_hilo + w_prod;
            OP_MSUB: w_result = w_hilo - w_prod;
            default: w_result = w_prod;
        endcase
    end

    // Sequencer FSM with HI/LO and the Done pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NONE;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= {WIDTH{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start && !Flush) begin
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                            r_op    <= Op;
                            r_neg   <= w_neg;
                        end else if (Op == OP_MTHI) begin
                            r_hi <= A;
                        end else if (Op == OP_MTLO) begin
                            r_lo <= A;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (Flush) begin
                        r_state <= ST_IDLE;
                    end else if (w_last) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_state <= ST_MUL;
                    end
                end
                ST_FIX: begin
                    if (Flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        {r_hi, r_lo} <= w_result;
                        r_done       <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Busy  = (r_state != ST_IDLE);
    assign Stall = Busy & (Start | ReadHiLo);
    assign Done  = r_done;
    assign Hi    = r_hi;
    assign Lo    = r_lo;

endmodule
